// File: rtl/pe_array_pkg.sv
// Shared types and lane arithmetic for the PE array result collector.
// Lanes are signed 16-bit values; a line packs LANES lanes, with lane 0 in the low bits.
package pe_array_pkg;

  localparam int DATA_W     = 16;
  localparam int LANES      = 7;
  localparam int LINES      = 3;
  localparam int LINE_IDX_W = 2;

  typedef logic signed [DATA_W-1:0] lane_t;
  typedef lane_t [LANES-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    DRAIN
  } state_t;

  // The sum is formed in DATA_W+1 bits; when the top two bits differ, it has overflowed.
  function automatic lane_t sat_add(input lane_t a, input lane_t b);
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return s[DATA_W-1:0];
  endfunction

  function automatic lane_t relu(input lane_t x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

  function automatic logic [LINES-1:0] line_sel(input logic [LINE_IDX_W-1:0] idx);
    logic [LINES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pe_line_accum.sv
// Lane-wise accumulate datapath for one output line.
// On pass 0 the incoming data is loaded as-is. On later passes it is added with saturation.
// The ReLU view of the stored line is also computed here.
module pe_line_accum
  import pe_array_pkg::*;
(
  input  line_t acc_in,
  input  line_t feat_in,
  input  logic  load,
  output line_t acc_out,
  output line_t relu_out
);

  always_comb begin
    acc_out  = '0;
    relu_out = '0;
    for (int k = 0; k < LANES; k++) begin
      acc_out[k]  = load ? feat_in[k] : sat_add(acc_in[k], feat_in[k]);
      relu_out[k] = relu(acc_in[k]);
    end
  end

endmodule

// File: rtl/pe_array_result_collector.sv
// Reads the PE array one output line at a time and accumulates NUM_CH passes per line.
// It then streams the ReLU'd lines downstream over a valid/ready handshake.
module pe_array_result_collector
  import pe_array_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int OUT_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pass_done,
  output logic [LINES-1:0]          output_en_line,
  input  logic [LANES*DATA_W-1:0]   feature_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      pass_overrun
);

  localparam int LAT_W = (OUT_LAT > 0) ? $clog2(OUT_LAT + 1) : 1;
  localparam int PC_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [LAT_W-1:0]      LAT_MAX   = LAT_W'(OUT_LAT);
  localparam logic [PC_W-1:0]       PC_MAX    = PC_W'(NUM_CH - 1);
  localparam logic [LINE_IDX_W-1:0] LAST_LINE = LINE_IDX_W'(LINES - 1);

  state_t                  state;
  logic [PC_W-1:0]         pass_cnt;
  logic [LINE_IDX_W-1:0]   line_idx;
  logic [LAT_W-1:0]        lat_cnt;
  line_t                   acc [LINES];
  line_t                   feat_line;
  line_t                   acc_next;
  line_t                   relu_line;
  logic                    sample;

  assign feat_line = feature_out;
  assign sample    = (state == SELECT) && (lat_cnt == LAT_MAX);

  // One datapath serves all lines. line_idx is the line being read in SELECT and the line being sent in DRAIN.
  pe_line_accum u_accum (
    .acc_in   (acc[line_idx]),
    .feat_in  (feat_line),
    .load     (pass_cnt == '0),
    .acc_out  (acc_next),
    .relu_out (relu_line)
  );

  // Accumulators are not reset; the first pass after reset always loads them.
  always_ff @(posedge clk) begin
    if (!rst && sample)
      acc[line_idx] <= acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pass_cnt       <= '0;
      line_idx       <= '0;
      lat_cnt        <= '0;
      output_en_line <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      pass_overrun   <= 1'b0;
    end else begin
      if (pass_done && state != IDLE)
        pass_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (pass_done) begin
            state          <= SELECT;
            line_idx       <= '0;
            lat_cnt        <= '0;
            output_en_line <= line_sel('0);
          end
        end
        SELECT: begin
          if (lat_cnt == LAT_MAX) begin
            lat_cnt <= '0;
            if (line_idx == LAST_LINE) begin
              output_en_line <= '0;
              line_idx       <= '0;
              if (pass_cnt == PC_MAX) begin
                state     <= DRAIN;
                out_valid <= 1'b1;
                out_last  <= (LAST_LINE == '0);
              end else begin
                pass_cnt <= pass_cnt + PC_W'(1);
                state    <= IDLE;
              end
            end else begin
              line_idx       <= line_idx + LINE_IDX_W'(1);
              output_en_line <= line_sel(line_idx + LINE_IDX_W'(1));
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (line_idx == LAST_LINE) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              pass_cnt  <= '0;
              line_idx  <= '0;
            end else begin
              line_idx <= line_idx + LINE_IDX_W'(1);
              out_last <= (line_idx + LINE_IDX_W'(1) == LAST_LINE);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_data = out_valid ? relu_line : '0;
  assign busy     = (state != IDLE) || (pass_cnt != '0);

endmodule

// File: tb/tb_pe_array_result_collector.sv
// Self-checking bench for pe_array_result_collector.
// It uses a one-pass instance (NUM_CH=1) and a four-pass instance (NUM_CH=4), each with a behavioural PE array model.
module tb_pe_array_result_collector;
  import pe_array_pkg::*;

  localparam int W = LANES * DATA_W;

  typedef struct packed {
    logic [2:0][15:0] pv;
    logic [2:0][15:0] ev;
  } vec_t;

  typedef struct packed {
    logic [15:0] lane;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic pd1, pd4, rdy1, rdy4;
  logic [2:0] en1, en4;
  logic [W-1:0] feat1, feat4, od1, od4;
  logic ov1, ov4, ol1, ol4, busy1, busy4, po1, po4;
  logic [15:0] line_val [3];

  exp_t exp_q [$];
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pe_array_result_collector #(.NUM_CH(1), .OUT_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .pass_done(pd1), .output_en_line(en1), .feature_out(feat1),
    .out_valid(ov1), .out_ready(rdy1), .out_data(od1), .out_last(ol1), .busy(busy1),
    .pass_overrun(po1)
  );

  pe_array_result_collector #(.NUM_CH(4), .OUT_LAT(1)) dut4 (
    .clk(clk), .rst(rst), .pass_done(pd4), .output_en_line(en4), .feature_out(feat4),
    .out_valid(ov4), .out_ready(rdy4), .out_data(od4), .out_last(ol4), .busy(busy4),
    .pass_overrun(po4)
  );

  function automatic logic [W-1:0] rep(input logic [15:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*16 +: 16] = v;
    return r;
  endfunction

  function automatic vec_t mkvec(input logic [15:0] p0, p1, p2, e0, e1, e2);
    vec_t v;
    v.pv[0] = p0; v.pv[1] = p1; v.pv[2] = p2;
    v.ev[0] = e0; v.ev[1] = e1; v.ev[2] = e2;
    return v;
  endfunction

  // PE array model: the selected line's data appears as soon as it is selected.
  always_comb begin
    case (en1)
      3'b001:  feat1 = rep(line_val[0]);
      3'b010:  feat1 = rep(line_val[1]);
      3'b100:  feat1 = rep(line_val[2]);
      default: feat1 = rep(16'hBAD0);
    endcase
    case (en4)
      3'b001:  feat4 = rep(line_val[0]);
      3'b010:  feat4 = rep(line_val[1]);
      3'b100:  feat4 = rep(line_val[2]);
      default: feat4 = rep(16'hBAD0);
    endcase
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic pushLine(input logic [15:0] v, input logic last);
    exp_t e;
    e.lane = v;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // One pass on dut4. The task returns one cycle after the pass ends.
  // extra > 0 places an additional pass_done pulse that many cycles into the pass.
  task automatic applyStimulus(input logic [15:0] v0, v1, v2, input int extra);
    line_val[0] = v0; line_val[1] = v1; line_val[2] = v2;
    @(posedge clk); #1 pd4 = 1'b1;
    @(posedge clk); #1 pd4 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == extra) pd4 = 1'b1;
      @(posedge clk); #1 pd4 = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL drain_timeout: got %0d lines pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard: every accepted drain line must match the oldest expected line.
  always @(negedge clk) begin
    if (!rst && ov4 && rdy4) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL unexpected_line: got %h, want no output", od4);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("drain_data", od4, rep(e.lane));
        checkOutput("drain_last", W'(ol4), W'(e.last));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [5];
    logic [2:0]  en_exp [6];
    logic [15:0] exp1 [3];
    logic [15:0] probe;

    vecs[0] = mkvec(16'h0100, 16'h0200, 16'hFF00, 16'h0400, 16'h0800, 16'h0000);
    vecs[1] = mkvec(16'h9000, 16'h7000, 16'h0001, 16'h0000, 16'h7FFF, 16'h0004);
    vecs[2] = mkvec(16'h0100, 16'h0100, 16'h0100, 16'h0400, 16'h0400, 16'h0400);
    vecs[3] = mkvec(16'h2000, 16'hE000, 16'h1FFF, 16'h7FFF, 16'h0000, 16'h7FFC);
    vecs[4] = mkvec(16'h7000, 16'h9000, 16'hC001, 16'h7FFF, 16'h0000, 16'h0000);
    en_exp = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    exp1   = '{16'h0100, 16'h0200, 16'h0000};

    rst = 1'b1; pd1 = 1'b0; pd4 = 1'b0; rdy1 = 1'b1; rdy4 = 1'b1;
    line_val = '{16'h0, 16'h0, 16'h0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("rst_en", W'(en4), '0);
    checkOutput("rst_valid", W'(ov4), '0);
    checkOutput("rst_data", od4, '0);
    checkOutput("rst_last", W'(ol4), '0);
    checkOutput("rst_busy", W'(busy4), '0);
    checkOutput("rst_overrun", W'(po4), '0);
    checkOutput("rst_valid1", W'(ov1), '0);

    // Single pass on the NUM_CH=1 instance: line select sequence, then three drained lines.
    line_val = '{16'h0100, 16'h0200, 16'hFF00};
    @(posedge clk); #1 pd1 = 1'b1;
    @(posedge clk); #1 pd1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("en_seq%0d", i), W'(en1), W'(en_exp[i]));
    end
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      checkOutput($sformatf("single_valid%0d", d), W'(ov1), W'(1'b1));
      checkOutput($sformatf("single_data%0d", d), od1, rep(exp1[d]));
      checkOutput($sformatf("single_last%0d", d), W'(ol1), W'(d == 2));
    end
    @(negedge clk);
    checkOutput("single_done", W'(ov1), '0);

    // Table-driven four-pass runs on the NUM_CH=4 instance.
    for (int i = 0; i < 5; i++) begin
      for (int l = 0; l < 3; l++) pushLine(vecs[i].ev[l], l == 2);
      for (int p = 0; p < 4; p++) begin
        applyStimulus(vecs[i].pv[0], vecs[i].pv[1], vecs[i].pv[2], 0);
        if (p < 3) begin
          checkOutput("busy_between", W'(busy4), W'(1'b1));
          checkOutput("no_early_valid", W'(ov4), '0);
        end
      end
      waitDrain();
      checkOutput("idle_after_drain", W'(busy4), '0);
      if (i == 1) begin
        probe = dut4.acc[0][0];
        checkOutput("probe_acc_sat", W'(probe), W'(16'h8000));
      end
    end

    // Backpressure: hold out_ready low for five cycles while line 1 is presented.
    for (int l = 0; l < 3; l++) pushLine(16'h0100 * 16'(l + 1), l == 2);
    for (int p = 0; p < 4; p++) applyStimulus(16'h0040, 16'h0080, 16'h00C0, 0);
    @(posedge clk); #1 rdy4 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_valid", W'(ov4), W'(1'b1));
      checkOutput("bp_data", od4, rep(16'h0200));
      checkOutput("bp_last", W'(ol4), '0);
    end
    @(posedge clk); #1 rdy4 = 1'b1;
    waitDrain();

    // Overrun: extra pulses during SELECT line 1, during DRAIN, and on the final handshake.
    checkOutput("overrun_clear", W'(po4), '0);
    for (int l = 0; l < 3; l++) pushLine(16'h0400 * 16'(l + 1), l == 2);
    for (int p = 0; p < 3; p++) applyStimulus(16'h0100, 16'h0200, 16'h0300, 0);
    applyStimulus(16'h0100, 16'h0200, 16'h0300, 3);
    checkOutput("overrun_set", W'(po4), W'(1'b1));
    pd4 = 1'b1;
    @(posedge clk); #1 pd4 = 1'b0;
    @(posedge clk); #1 pd4 = 1'b1;
    @(posedge clk); #1 pd4 = 1'b0;
    @(posedge clk); #1;
    checkOutput("overrun_no_start", W'(en4), '0);
    checkOutput("overrun_idle", W'(busy4), '0);
    checkOutput("overrun_sticky", W'(po4), W'(1'b1));
    checkOutput("overrun_drained", W'(exp_q.size()), '0);

    // Reset in the middle of the second pass, then a clean four-pass run.
    applyStimulus(16'h1234, 16'h2345, 16'h3456, 0);
    @(posedge clk); #1 pd4 = 1'b1;
    @(posedge clk); #1 pd4 = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checkOutput("midrst_en", W'(en4), '0);
    checkOutput("midrst_valid", W'(ov4), '0);
    checkOutput("midrst_data", od4, '0);
    checkOutput("midrst_last", W'(ol4), '0);
    checkOutput("midrst_busy", W'(busy4), '0);
    checkOutput("midrst_overrun", W'(po4), '0);
    for (int l = 0; l < 3; l++) pushLine(16'h0004, l == 2);
    for (int p = 0; p < 4; p++) applyStimulus(16'h0001, 16'h0001, 16'h0001, 0);
    waitDrain();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pe_array_result_collector.md
Name: pe_array_result_collector

Overview:
- Reader side of the pe_array output interface.
- Drives the 3-bit one-hot output_en_line select into the PE array and samples the 112-bit feature_out bus (7 lanes x 16-bit) for each of the 3 output lines.
- Accumulates partial sums across NUM_CH input-channel passes with saturation, applies ReLU, then streams the 3 finished lines to the downstream feature buffer over a valid/ready handshake.

Parameters:
- LANES, 7, 16-bit lanes per output line.
- DATA_W, 16, lane width, signed two's complement.
- LINES, 3, output lines per pass; width of output_en_line.
- NUM_CH, 4, passes accumulated before drain; must be at least 1.
- OUT_LAT, 1, cycles from output_en_line assertion to valid feature_out; must be at least 1.

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, synchronous reset, active-high.
- pass_done, input, 1, single-cycle pulse: PE array holds a completed pass on all lines.
- output_en_line, output, LINES, one-hot line select into pe_array.
- feature_out, input, LANES*DATA_W, PE array line data; lane k occupies bits [16k+15:16k].
- out_valid, output, 1, result line available.
- out_ready, input, 1, downstream accepts the result line.
- out_data, output, LANES*DATA_W, ReLU'd line, same lane packing as feature_out.
- out_last, output, 1, high with the final line (index 2) of a drain.
- busy, output, 1, high in any state other than IDLE, or while pass_cnt is nonzero.
- pass_overrun, output, 1, sticky error flag; cleared only by rst.

Behaviour:
- Reset values: all outputs 0; state IDLE; pass_cnt=0; line_idx=0. Accumulators are not cleared, because pass 0 loads them.
- States are IDLE, SELECT and DRAIN.
- IDLE:
  - A pass_done at cycle t moves to SELECT.
  - output_en_line becomes 3'b001 in cycle t+1 (registered output).
- SELECT, per line i:
  - output_en_line = one-hot(i), held for OUT_LAT+1 cycles, c..c+OUT_LAT.
  - feature_out is sampled at the edge ending cycle c+OUT_LAT.
  - Pass 0 loads acc[i]. Later passes set acc[i] = sat_add(acc[i], feature_out) lane-wise.
  - Next line starts with no gap. A pass takes 3*(OUT_LAT+1) cycles.
  - After line 2 on a pass with pass_cnt<NUM_CH-1: increment pass_cnt, return to IDLE, output_en_line=0.
  - After line 2 on a pass with pass_cnt==NUM_CH-1: go to DRAIN, output_en_line=0.
- DRAIN:
  - out_valid=1.
  - out_data = relu(acc[d]) lane-wise, for d=0,1,2.
  - out_last=1 when d==2.
  - On out_valid&&out_ready, advance d.
  - While out_ready is low, out_data and out_last hold stable and out_valid stays high.
  - After the handshake on d==2: go to IDLE, pass_cnt=0, out_valid=0 the next cycle.
  - Minimum drain is 3 cycles.
- Arithmetic:
  - Signed 16-bit; the sum is computed in 17 bits.
  - Results clamp to 32767 / -32768.
  - relu(x) = 0 if x<0, else x.
- Boundary conditions:
  - pass_done while in SELECT or DRAIN: ignored, pass_overrun set to 1, no state change.
  - pass_done in the same cycle as the final drain handshake: ignored, flagged.
  - rst mid-SELECT or mid-DRAIN:
    - Next cycle is IDLE with all outputs 0.
    - Any partial accumulation is discarded; the next pass is treated as pass 0.
  - out_ready high outside DRAIN: no effect.
  - NUM_CH=1: every pass drains.

Decomposition:
- Package pe_array_pkg holds:
  - DATA_W, LANES, LINES.
  - typedef lane_t (signed [15:0]).
  - typedef line_t (lane_t [LANES-1:0]).
  - Functions sat_add and relu.
- Sub-module pe_line_accum: combinational 7-lane sat_add/load mux plus ReLU output path, instantiated once and muxed by line index.

Test Plan:
- Single pass, NUM_CH=1, OUT_LAT=1:
  - Stimulus: pass_done pulse; feature_out lane value 0x0100 on line 0, 0x0200 on line 1, 0xFF00 (-256) on line 2; out_ready=1.
  - Required: output_en_line sequence 001,001,010,010,100,100.
  - Required: out_data lanes 0x0100, then 0x0200, then 0x0000; out_last only on the third line.
- Accumulation, NUM_CH=4:
  - Stimulus: 4 passes, each with all lanes 0x0100.
  - Required: drained lanes 0x0400.
  - Required: busy stays high between passes; no out_valid before pass 4 completes.
- Saturation:
  - Stimulus: 4 passes of 0x7000.
  - Required: lanes 0x7FFF.
  - Stimulus: 4 passes of 0x9000.
  - Required: lanes 0x0000 after ReLU; an internal probe shows acc 0x8000.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles at drain line 1.
  - Required: out_data holds 0x0200 lanes with out_valid high; drain completes after out_ready rises.
  - Required: no lines dropped or duplicated.
- Overrun:
  - Stimulus: pass_done during SELECT line 1, and again during DRAIN.
  - Required: pass_overrun goes to 1 and stays 1; outputs are identical to a run without the extra pulses.
- Reset mid-operation:
  - Stimulus: rst during pass 2 of 4, then 4 clean passes of 0x0001.
  - Required: all outputs 0 the cycle after rst; drained lanes 0x0004.
